// File: rtl/emac_rx_frame_writer.sv
// ----------------------------------------------------------------------------
// emac_rx_frame_writer
//
// Receive-side framing stage for one EMAC port. Strips preamble/SFD from the
// GMII receive stream and writes every frame byte into the rx data FIFO. Once
// the frame ends, it writes one 16-bit descriptor into the rx pointer FIFO:
//     {crc_error, length_error, 3'b0, length[10:0]}
// Space in both FIFOs is checked once per frame, at the SFD, so no full flag
// is examined per byte.
//
// Ports:
//   clk                 single clock (block and FIFO write side)
//   rst                 synchronous, active-high reset
//   rx_dv, rx_er, rxd   GMII receive data valid / error / byte
//   data_fifo_wr/_din   data FIFO write enable and byte
//   data_fifo_wr_count  data FIFO fill level (write side)
//   ptr_fifo_wr/_din    pointer FIFO write enable and descriptor
//   ptr_fifo_full       pointer FIFO full
//   frame_cnt           descriptors written (wraps)
//   drop_cnt            frames discarded without a descriptor (wraps)
// ----------------------------------------------------------------------------
module emac_rx_frame_writer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int DEPTH   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic        data_fifo_wr,
    output logic [7:0]  data_fifo_din,
    input  logic [11:0] data_fifo_wr_count,
    output logic        ptr_fifo_wr,
    output logic [15:0] ptr_fifo_din,
    input  logic        ptr_fifo_full,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_COMMIT,
        S_DROP
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] rcv_len_q, rcv_len_d;
    logic [10:0] wr_len_q, wr_len_d;
    logic        rx_err_q, rx_err_d;
    logic        byte_wr_q, byte_wr_d;
    logic [7:0]  byte_q, byte_d;
    logic        data_fifo_wr_q, data_fifo_wr_d;
    logic [7:0]  data_fifo_din_q, data_fifo_din_d;
    logic        ptr_fifo_wr_q, ptr_fifo_wr_d;
    logic [15:0] ptr_fifo_din_q, ptr_fifo_din_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic [31:0] free_space;
    logic        admit;
    logic        crc_error;
    logic        length_error;

    // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Admission: a whole maximum-length frame must fit and a descriptor slot
    // must be free, so nothing needs checking once the frame is under way.
    assign free_space   = 32'(DEPTH - 1) - {20'd0, data_fifo_wr_count};
    assign admit        = (free_space >= 32'(MAX_LEN)) && !ptr_fifo_full;
    assign crc_error    = (crc_q != CRC_RESIDUE) || rx_err_q;
    assign length_error = (rcv_len_q < 11'(MIN_LEN)) || (rcv_len_q > 11'(MAX_LEN));

    // Next-state and datapath. Bytes accepted in DATA are staged in byte_q and
    // then registered again onto the FIFO port, which keeps the last data write
    // strictly ahead of the descriptor write issued from COMMIT.
    always_comb begin
        state_d         = state_q;
        crc_d           = crc_q;
        rcv_len_d       = rcv_len_q;
        wr_len_d        = wr_len_q;
        rx_err_d        = rx_err_q;
        byte_wr_d       = 1'b0;
        byte_d          = byte_q;
        data_fifo_wr_d  = byte_wr_q;
        data_fifo_din_d = byte_q;
        ptr_fifo_wr_d   = 1'b0;
        ptr_fifo_din_d  = ptr_fifo_din_q;
        frame_cnt_d     = frame_cnt_q;
        drop_cnt_d      = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (rx_dv) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rxd == 8'h55) begin
                    state_d = S_PRE;
                end else if (rxd == 8'hD5 && admit) begin
                    state_d   = S_DATA;
                    crc_d     = 32'hFFFFFFFF;
                    rcv_len_d = '0;
                    wr_len_d  = '0;
                    rx_err_d  = 1'b0;
                end else begin
                    state_d    = S_DROP;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_er) begin
                    rx_err_d = 1'b1;
                end
                if (rx_dv) begin
                    crc_d = crc_next(crc_q, rxd);
                    if (rcv_len_q != 11'h7FF) begin
                        rcv_len_d = rcv_len_q + 11'd1;
                    end
                    if (wr_len_q < 11'(MAX_LEN)) begin
                        byte_wr_d = 1'b1;
                        byte_d    = rxd;
                        wr_len_d  = wr_len_q + 11'd1;
                    end
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                // A frame that wrote nothing has no descriptor; count it as dropped.
                if (wr_len_q == 11'd0) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end else begin
                    ptr_fifo_wr_d  = 1'b1;
                    ptr_fifo_din_d = {crc_error, length_error, 3'b000, wr_len_q};
                    frame_cnt_d    = frame_cnt_q + 16'd1;
                end
            end
            S_DROP: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_DROP;
            end
        endcase
    end

    // State register. Reset lands in DROP so a frame already on the wire when
    // reset is released is ignored until rx_dv falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_DROP;
            crc_q           <= '0;
            rcv_len_q       <= '0;
            wr_len_q        <= '0;
            rx_err_q        <= 1'b0;
            byte_wr_q       <= 1'b0;
            byte_q          <= '0;
            data_fifo_wr_q  <= 1'b0;
            data_fifo_din_q <= '0;
            ptr_fifo_wr_q   <= 1'b0;
            ptr_fifo_din_q  <= '0;
            frame_cnt_q     <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            crc_q           <= crc_d;
            rcv_len_q       <= rcv_len_d;
            wr_len_q        <= wr_len_d;
            rx_err_q        <= rx_err_d;
            byte_wr_q       <= byte_wr_d;
            byte_q          <= byte_d;
            data_fifo_wr_q  <= data_fifo_wr_d;
            data_fifo_din_q <= data_fifo_din_d;
            ptr_fifo_wr_q   <= ptr_fifo_wr_d;
            ptr_fifo_din_q  <= ptr_fifo_din_d;
            frame_cnt_q     <= frame_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign data_fifo_wr  = data_fifo_wr_q;
    assign data_fifo_din = data_fifo_din_q;
    assign ptr_fifo_wr   = ptr_fifo_wr_q;
    assign ptr_fifo_din  = ptr_fifo_din_q;
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_emac_rx_frame_writer.sv
// ----------------------------------------------------------------------------
// tb_emac_rx_frame_writer
//
// Drives GMII frames into emac_rx_frame_writer. Each frame's expected FIFO
// bytes and descriptor are derived from the frame contents and pushed into
// queues; an independent monitor pops and compares on every FIFO write.
// ----------------------------------------------------------------------------
module tb_emac_rx_frame_writer;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int DEPTH   = 4096;

    typedef struct packed {
        logic [15:0] desc;
        logic [15:0] fcnt;
    } descExp_t;

    logic        clk;
    logic        rst;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rxd;
    logic        data_fifo_wr;
    logic [7:0]  data_fifo_din;
    logic [11:0] data_fifo_wr_count;
    logic        ptr_fifo_wr;
    logic [15:0] ptr_fifo_din;
    logic        ptr_fifo_full;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] frm[$];
    logic [7:0] dataQ[$];
    descExp_t   descQ[$];
    logic [15:0] frameModel = 0;
    logic [15:0] dropModel  = 0;
    bit          ignoreData = 0;

    emac_rx_frame_writer #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_dv             (rx_dv),
        .rx_er             (rx_er),
        .rxd               (rxd),
        .data_fifo_wr      (data_fifo_wr),
        .data_fifo_din     (data_fifo_din),
        .data_fifo_wr_count(data_fifo_wr_count),
        .ptr_fifo_wr       (ptr_fifo_wr),
        .ptr_fifo_din      (ptr_fifo_din),
        .ptr_fifo_full     (ptr_fifo_full),
        .frame_cnt         (frame_cnt),
        .drop_cnt          (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard Ethernet CRC-32 (final value complemented) over frm[0..count-1].
    function automatic logic [31:0] crc32Of(input int count);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < count; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic void appendFcs(input bit bad);
        logic [31:0] f;
        f = bad ? 32'h12345678 : crc32Of(frm.size());
        frm.push_back(f[7:0]);
        frm.push_back(f[15:8]);
        frm.push_back(f[23:16]);
        frm.push_back(f[31:24]);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
        end
    endtask

    // Monitor: every FIFO write is compared against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_fifo_wr && !ignoreData) begin
                checks++;
                if (dataQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_data_write: got 0x%02h expected none", data_fifo_din);
                end else begin
                    logic [7:0] e;
                    e = dataQ.pop_front();
                    if (data_fifo_din !== e) begin
                        errors++;
                        $display("[TB] FAIL data_byte: got 0x%02h expected 0x%02h", data_fifo_din, e);
                    end
                end
            end
            if (ptr_fifo_wr) begin
                checks++;
                if (descQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_descriptor: got 0x%04h expected none", ptr_fifo_din);
                end else begin
                    descExp_t d;
                    d = descQ.pop_front();
                    if (ptr_fifo_din !== d.desc || frame_cnt !== d.fcnt || dataQ.size() != 0) begin
                        errors++;
                        $display("[TB] FAIL descriptor: got desc 0x%04h frame_cnt %0d bytes_left %0d expected desc 0x%04h frame_cnt %0d bytes_left 0",
                                 ptr_fifo_din, frame_cnt, dataQ.size(), d.desc, d.fcnt);
                    end
                end
            end
        end
    end

    task automatic driveByte(input logic [7:0] b, input logic er);
        rxd   = b;
        rx_er = er;
        rx_dv = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Builds expectations for the frame in frm, then drives it on GMII.
    task automatic applyStimulus(input int preLen, input bit badPre, input int erPos,
                                 input logic [11:0] wrCount, input bit pFull);
        bit          admitted;
        int          n;
        int          rcv;
        bit          crcOk;
        bit          lenErr;
        descExp_t    d;
        logic [31:0] fcsRx;

        admitted = !badPre && ((DEPTH - 1 - int'(wrCount)) >= MAX_LEN) && !pFull;
        if (!admitted || frm.size() == 0) begin
            dropModel++;
        end else begin
            n   = (frm.size() < MAX_LEN) ? frm.size() : MAX_LEN;
            rcv = (frm.size() < 2047) ? frm.size() : 2047;
            for (int i = 0; i < n; i++) dataQ.push_back(frm[i]);
            crcOk = 1'b0;
            if (frm.size() >= 4) begin
                fcsRx = {frm[frm.size()-1], frm[frm.size()-2], frm[frm.size()-3], frm[frm.size()-4]};
                crcOk = (crc32Of(frm.size() - 4) == fcsRx);
            end
            lenErr = (rcv < MIN_LEN) || (rcv > MAX_LEN);
            frameModel++;
            d.desc = {!crcOk || (erPos >= 0), lenErr, 3'b000, 11'(n)};
            d.fcnt = frameModel;
            descQ.push_back(d);
        end

        for (int i = 0; i < preLen; i++) driveByte(8'h55, 1'b0);
        if (badPre) driveByte(8'h5A, 1'b0);
        data_fifo_wr_count = wrCount;
        ptr_fifo_full      = pFull;
        driveByte(8'hD5, 1'b0);
        data_fifo_wr_count = 12'd0;
        ptr_fifo_full      = 1'b0;
        for (int i = 0; i < frm.size(); i++) driveByte(frm[i], (i == erPos));
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd   = 8'h00;
        repeat (14) @(posedge clk);
        #1;
        checkOutput("frame_cnt", frame_cnt, frameModel);
        checkOutput("drop_cnt", drop_cnt, dropModel);
        checkOutput("pending_bytes", 16'(dataQ.size()), 16'd0);
        checkOutput("pending_descriptors", 16'(descQ.size()), 16'd0);
        dataQ.delete();
        descQ.delete();
    endtask

    task automatic buildTestFrame(input int payloadLen, input bit badFcs);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(8'hF0 + 8'(i));
        for (int i = 0; i < 6; i++) frm.push_back(8'hE0 + 8'(i));
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 0; i < payloadLen - 14; i++) frm.push_back(8'(i));
        appendFcs(badFcs);
    endtask

    initial begin
        int len;
        rst = 1'b1;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd = 8'h00;
        data_fifo_wr_count = 12'd0;
        ptr_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data_fifo_wr", 16'(data_fifo_wr), 16'd0);
        checkOutput("reset_data_fifo_din", 16'(data_fifo_din), 16'd0);
        checkOutput("reset_ptr_fifo_wr", 16'(ptr_fifo_wr), 16'd0);
        checkOutput("reset_ptr_fifo_din", ptr_fifo_din, 16'd0);
        checkOutput("reset_frame_cnt", frame_cnt, 16'd0);
        checkOutput("reset_drop_cnt", drop_cnt, 16'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] good frame");
        buildTestFrame(100, 0);
        applyStimulus(7, 0, -1, 12'd0, 0);
        checkOutput("good_descriptor", ptr_fifo_din, 16'h0068);

        $display("[TB] bad fcs");
        buildTestFrame(100, 1);
        applyStimulus(7, 0, -1, 12'd0, 0);
        checkOutput("bad_fcs_descriptor", ptr_fifo_din, 16'h8068);

        $display("[TB] runt");
        buildTestFrame(40, 0);
        applyStimulus(7, 0, -1, 12'd0, 0);
        checkOutput("runt_descriptor", ptr_fifo_din, 16'h402C);

        $display("[TB] giant");
        buildTestFrame(1600, 0);
        applyStimulus(7, 0, -1, 12'd0, 0);
        checkOutput("giant_descriptor", ptr_fifo_din, 16'h45EE);

        $display("[TB] no space then accepted");
        buildTestFrame(80, 0);
        applyStimulus(7, 0, -1, 12'd3000, 0);
        buildTestFrame(80, 0);
        applyStimulus(7, 0, -1, 12'd0, 0);

        $display("[TB] rx_er mid-frame");
        buildTestFrame(100, 0);
        applyStimulus(7, 0, 50, 12'd0, 0);
        checkOutput("rx_er_bit15", 16'(ptr_fifo_din[15]), 16'd1);

        $display("[TB] empty, pointer full, bad preamble");
        frm.delete();
        applyStimulus(7, 0, -1, 12'd0, 0);
        buildTestFrame(70, 0);
        applyStimulus(3, 0, -1, 12'd0, 1);
        buildTestFrame(70, 0);
        applyStimulus(2, 1, -1, 12'd0, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 24; f++) begin
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1500, 1540)) : int'($urandom_range(0, 130));
            frm.delete();
            if (len >= 4) begin
                for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
                appendFcs($urandom_range(0, 3) == 0);
            end else begin
                for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
            end
            applyStimulus(int'($urandom_range(1, 7)),
                          $urandom_range(0, 9) == 0,
                          (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                          ($urandom_range(0, 4) == 0) ? 12'($urandom) : 12'd0,
                          $urandom_range(0, 7) == 0);
        end

        $display("[TB] reset mid-frame");
        ignoreData = 1;
        buildTestFrame(60, 0);
        for (int i = 0; i < 7; i++) driveByte(8'h55, 1'b0);
        driveByte(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) driveByte(frm[i], 1'b0);
        rst = 1'b1;
        driveByte(frm[10], 1'b0);
        checkOutput("midreset_frame_cnt", frame_cnt, 16'd0);
        checkOutput("midreset_drop_cnt", drop_cnt, 16'd0);
        checkOutput("midreset_data_fifo_wr", 16'(data_fifo_wr), 16'd0);
        driveByte(frm[11], 1'b0);
        rst = 1'b0;
        frameModel = 0;
        dropModel  = 0;
        dataQ.delete();
        descQ.delete();
        for (int i = 12; i < frm.size(); i++) driveByte(frm[i], 1'b0);
        rx_dv = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        ignoreData = 0;
        checkOutput("after_reset_frame_cnt", frame_cnt, 16'd0);
        checkOutput("after_reset_drop_cnt", drop_cnt, 16'd0);
        buildTestFrame(100, 0);
        applyStimulus(7, 0, -1, 12'd0, 0);
        checkOutput("after_reset_frame_one", frame_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
